// File: rtl/edge_pkg.sv
// Shared constants and the luma helper for the edge threshold stage.
package edge_pkg;

  // Widest colour channel the luma helper accepts; narrower channels are zero-extended.
  localparam int LUMA_W = 16;

  // All-ones pixel value; callers slice the low PIXEL_DEPTH bits.
  localparam logic [LUMA_W-1:0] PIXEL_MAX = 16'hFFFF;

  // Luma weights are 1:2:1, so the sum is normalised by a shift of 2.
  localparam int LUMA_SHIFT = 2;

  // luma = (R + 2*G + B) >> 2; two guard bits keep the sum from overflowing.
  function automatic logic [LUMA_W-1:0] luma(
    input logic [LUMA_W-1:0] r,
    input logic [LUMA_W-1:0] g,
    input logic [LUMA_W-1:0] b
  );
    logic [LUMA_W+1:0] sum_s;
    sum_s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return LUMA_W'(sum_s >> LUMA_SHIFT);
  endfunction

endpackage

// File: rtl/edge_threshold_stage_raster.sv
// Raster position tracker: column/row of the next pixel, stepped on advance.
module raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             first,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

  logic col_end_s;
  logic row_end_s;

  // Decode line end, frame end and frame start from the current position.
  always_comb begin
    col_end_s = (col == COL_MAX);
    row_end_s = (row == ROW_MAX);
    first     = (col == COL_ZERO) && (row == ROW_ZERO);
    last      = col_end_s && row_end_s;
  end

  // Step one pixel per advance, wrapping the column into the row and the row into the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= COL_ZERO;
      row <= ROW_ZERO;
    end else if (advance) begin
      if (col_end_s) begin
        col <= COL_ZERO;
        if (row_end_s) begin
          row <= ROW_ZERO;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_threshold_stage.sv
// Luma threshold stage: binarises filtered RGB, blacks out the kernel halo and
// counts edge pixels per frame. Fixed two-cycle latency, no backpressure.
module edge_threshold_stage
  import edge_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int PIXEL_DEPTH = 8,
  parameter int BORDER      = 1,
  parameter int COUNT_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  input  logic [PIXEL_DEPTH-1:0] input_R,
  input  logic [PIXEL_DEPTH-1:0] input_G,
  input  logic [PIXEL_DEPTH-1:0] input_B,
  input  logic [PIXEL_DEPTH-1:0] threshold,
  input  logic                   invert,
  output logic                   valid_o,
  output logic [PIXEL_DEPTH-1:0] output_R,
  output logic [PIXEL_DEPTH-1:0] output_G,
  output logic [PIXEL_DEPTH-1:0] output_B,
  output logic                   edge_o,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] edge_count
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [PIXEL_DEPTH-1:0] PIX_ONES = PIXEL_MAX[PIXEL_DEPTH-1:0];
  localparam logic [PIXEL_DEPTH-1:0] PIX_ZERO = {PIXEL_DEPTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};

  // Interior window bounds; anything outside is halo.
  localparam logic [COL_W-1:0] COL_LO = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_HI = COL_W'(WIDTH - 1 - BORDER);
  localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(HEIGHT - 1 - BORDER);

  logic [COL_W-1:0]       col_s;
  logic [ROW_W-1:0]       row_s;
  logic                   first_s;
  logic                   last_s;

  logic [PIXEL_DEPTH-1:0] threshold_r;
  logic                   invert_r;

  logic                   v1_r;
  logic [PIXEL_DEPTH-1:0] luma1_r;
  logic [COL_W-1:0]       col1_r;
  logic [ROW_W-1:0]       row1_r;
  logic                   last1_r;

  logic                   border_s;
  logic                   edge_s;
  logic [PIXEL_DEPTH-1:0] pix_s;

  logic [COUNT_WIDTH-1:0] running_r;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (valid_i),
    .col     (col_s),
    .row     (row_s),
    .first   (first_s),
    .last    (last_s)
  );

  // Capture threshold/invert with the first pixel so a whole frame sees one setting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      threshold_r <= PIX_ZERO;
      invert_r    <= 1'b0;
    end else if (valid_i && first_s) begin
      threshold_r <= threshold;
      invert_r    <= invert;
    end
  end

  // Stage 1: luma plus the position tags the border/last logic needs downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r    <= 1'b0;
      luma1_r <= PIX_ZERO;
      col1_r  <= {COL_W{1'b0}};
      row1_r  <= {ROW_W{1'b0}};
      last1_r <= 1'b0;
    end else begin
      v1_r <= valid_i;
      if (valid_i) begin
        luma1_r <= PIXEL_DEPTH'(luma(LUMA_W'(input_R), LUMA_W'(input_G), LUMA_W'(input_B)));
        col1_r  <= col_s;
        row1_r  <= row_s;
        last1_r <= last_s;
      end
    end
  end

  // Stage 2 decision: halo mask, threshold compare, then polarity for the output pixel.
  always_comb begin
    border_s = (col1_r < COL_LO) || (col1_r > COL_HI) ||
               (row1_r < ROW_LO) || (row1_r > ROW_HI);
    edge_s   = !border_s && (luma1_r >= threshold_r);
    if (border_s) begin
      pix_s = PIX_ZERO;
    end else if (edge_s ^ invert_r) begin
      pix_s = PIX_ONES;
    end else begin
      pix_s = PIX_ZERO;
    end
  end

  // Stage 2 registers: pixel outputs hold through bubbles; frame_done marks the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o    <= 1'b0;
      output_R   <= PIX_ZERO;
      output_G   <= PIX_ZERO;
      output_B   <= PIX_ZERO;
      edge_o     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_o    <= v1_r;
      frame_done <= v1_r && last1_r;
      if (v1_r) begin
        output_R <= pix_s;
        output_G <= pix_s;
        output_B <= pix_s;
        edge_o   <= edge_s;
      end
    end
  end

  // Edge statistics: accumulate per frame, publish and restart on the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_r  <= CNT_ZERO;
      edge_count <= CNT_ZERO;
    end else if (v1_r) begin
      if (last1_r) begin
        edge_count <= running_r + COUNT_WIDTH'(edge_s);
        running_r  <= CNT_ZERO;
      end else begin
        running_r  <= running_r + COUNT_WIDTH'(edge_s);
      end
    end
  end

endmodule

// File: doc/edge_threshold_stage.md
Name: edge_threshold_stage

Overview:
Streaming post-processing stage that sits directly downstream of conv_kernel and feeds image_dumper (simulation) or the VGA output path (hardware).
- Converts each filtered RGB pixel to luma.
- Compares the luma against a per-frame threshold.
- Forces the kernel halo border to black.
- Emits a binary white/black RGB pixel.
- Reports a per-frame edge-pixel count with a frame_done pulse.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
PIXEL_DEPTH, 8, bits per colour channel
BORDER, 1, halo width in pixels masked on every frame edge (SIZE/2 of the upstream kernel)
COUNT_WIDTH, 19, width of the edge counter (must hold WIDTH*HEIGHT)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
valid_i  in  1  input pixel valid (from conv_kernel valid_o)
input_R  in  PIXEL_DEPTH  filtered red
input_G  in  PIXEL_DEPTH  filtered green
input_B  in  PIXEL_DEPTH  filtered blue
threshold  in  PIXEL_DEPTH  edge threshold, sampled per frame
invert  in  1  1 = edges black on white, sampled per frame
valid_o  out  1  output pixel valid
output_R  out  PIXEL_DEPTH  binary pixel, all-ones or zero
output_G  out  PIXEL_DEPTH  same value as output_R
output_B  out  PIXEL_DEPTH  same value as output_R
edge_o  out  1  raw edge decision for the current output pixel, before invert
frame_done  out  1  one-cycle pulse with the last pixel of a frame
edge_count  out  COUNT_WIDTH  edge pixels in the last completed frame

Behaviour:
Clock and reset:
- Single clock, clk. Reset is asynchronous and active-low on reset_n.
- On reset, every output, pipeline register, counter and sampled control register is 0.
- Reset mid-frame discards all in-flight pixels; the next valid_i pixel is position (0,0).

Raster position:
- col/row advance only on valid_i.
- col wraps from WIDTH-1 to 0 and increments row.
- row wraps from HEIGHT-1 to 0.
- Gaps in valid_i freeze the position. There is no backpressure.

Per-frame control sampling:
- threshold and invert are captured into internal registers when valid_i is high at (0,0).
- That pixel and the rest of the frame use the newly captured values.
- Changes to threshold or invert mid-frame take effect at the next frame.

Pipeline (fixed 2-cycle latency; valid_o is valid_i delayed by 2 cycles, bubbles preserved):
- Stage 1: luma = (R + 2*G + B) >> 2.
  - Computed in 10 bits and truncated to PIXEL_DEPTH; this never overflows.
  - The stage also registers col, row, and a last flag (col==WIDTH-1 && row==HEIGHT-1).
- Stage 2 border test:
  - border = col < BORDER, or col > WIDTH-1-BORDER, or row < BORDER, or row > HEIGHT-1-BORDER.
- Stage 2 edge decision:
  - edge = !border && (luma >= threshold_q).
  - threshold_q = 0 therefore marks every interior pixel as an edge.
- Stage 2 pixel value:
  - pix = border ? 0 : (edge ^ invert_q) ? all-ones : 0.
  - Border pixels are always black, regardless of invert.
- Stage 2 outputs:
  - output_R/G/B = pix.
  - edge_o = edge.
  - All outputs are registered and hold their last value while valid_o is 0.

Frame statistics:
- A running counter increments on each stage-2 valid pixel with edge=1.
- On the stage-2 valid pixel carrying last:
  - edge_count <= running + edge.
  - running <= 0.
  - frame_done = 1 for exactly that cycle, coincident with valid_o.
- edge_count holds its value until the next frame completes.
- invert does not affect counting.

Decomposition:
- Package edge_pkg holds:
  - PIXEL_MAX (all-ones constant).
  - Luma weight shift constant.
  - A luma function computing (R + 2G + B) >> 2.
- Sub-module raster_counter (parameters WIDTH and HEIGHT; inputs clk, reset_n, advance; outputs col, row, first, last).
  - Also reusable for the row/col counting in RGB_Process stimulus.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4, BORDER=1 (12 interior pixels).
1. reset_n held low with random inputs -> valid_o, frame_done, edge_count and outputs all 0; releasing reset mid-frame restarts at (0,0).
2. Latency and luma: R=G=B=100, threshold=100, one pixel at interior (1,1) -> valid_o exactly 2 cycles after valid_i, output 255/255/255, edge_o=1; with R=0, G=100, B=0 (luma 50) -> output 0.
3. Full frame of R=G=B=255, threshold=1, contiguous valid_i -> 32 outputs, all border pixels 0, 12 interior pixels 255; frame_done high only on the 32nd valid_o; edge_count=12.
4. Same frame with valid_i toggled every other cycle -> identical pixel sequence and edge_count=12; valid_o gaps match input gaps 2 cycles later.
5. threshold changed from 1 to 255 at pixel 10 of a frame of value 200 -> that frame still counts 12; next frame counts 0.
6. invert=1 with the scenario 3 frame -> interior pixels 0, border pixels 0, edge_o=1 on interior pixels, edge_count=12.
